turn_sequencer: RTL and testbench
=================================

// Module: turn_sequencer
// PURPOSE
//  Upstream game-logic stage for the two-player board. Accepts die rolls and tracks each
//  player's tile index (0 = start, FLAG_TILE = flag). Converts the new tile to a target
//  x pixel and pulses the matching move_start. Waits for that player's turn_done, then
//  hands the turn to the other player. Detects the winner and, after a turn_done timeout,
//  recovers the turn.
// PARAMETERS
//  START_X        20      x pixel of tile 0
//  TILE_SPACING   60      pixels per tile
//  FLAG_TILE      10      flag tile index; target_x = START_X + FLAG_TILE*TILE_SPACING = 620
//  TIMEOUT_CYCLES 2**22   cycles to wait for turn_done before forcing the turn to end
// PORTS
//  clk                 in   1   system clock
//  rst                 in   1   synchronous reset, active-high
//  roll_valid          in   1   die roll presented
//  roll_value          in   3   die value; only 1..6 are legal
//  roll_ready          out  1   high only in WAIT_ROLL
//  new_game            in   1   leaves GAME_OVER and restarts the game
//  player1_turn_done   in   1   1-cycle pulse from the movement controller
//  player2_turn_done   in   1   1-cycle pulse from the movement controller
//  player1_target_x    out  10  registered target pixel for P1
//  player1_move_start  out  1   1-cycle pulse
//  player2_target_x    out  10  registered target pixel for P2
//  player2_move_start  out  1   1-cycle pulse
//  active_player       out  1   0 = P1, 1 = P2
//  player1_tile        out  4   committed tile of P1
//  player2_tile        out  4   committed tile of P2
//  game_over           out  1   level; winner is valid while high
//  winner              out  1   0 = P1, 1 = P2
//  bad_roll            out  1   1-cycle pulse when an illegal roll is dropped
//  timeout_err         out  1   1-cycle pulse when the watchdog fires
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge)
//  - state = WAIT_ROLL; active_player = 0; both tiles = 0.
//  - Both target_x = START_X. All pulses = 0; game_over = 0; winner = 0.
//  FSM states: WAIT_ROLL -> ISSUE -> WAIT_DONE -> COMMIT -> WAIT_ROLL | GAME_OVER
//  WAIT_ROLL
//  - roll_ready = 1. A roll is accepted when roll_valid && roll_value in 1..6.
//  - On accept: pend_tile = min(tile[active] + roll_value, FLAG_TILE). Overshoot clamps
//    to the flag. Arithmetic is 5-bit; no wrap.
//  - roll_valid with value 0 or 7: bad_roll pulses the next cycle; state and tiles are unchanged.
//  ISSUE (1 cycle)
//  - target_x[active] <= START_X + pend_tile*TILE_SPACING, computed as a constant multiply.
//  - move_start[active] <= 1 for exactly this one registered cycle.
//  - The target is stable at least 1 cycle before the pulse rises and is held until the next ISSUE.
//  - The inactive player's target_x and move_start do not change.
//  WAIT_DONE
//  - The watchdog counts from 0 on entry.
//  - turn_done of the active player -> COMMIT.
//  - turn_done of the inactive player is ignored.
//  - Both turn_done pulses in the same cycle: only the active player's counts.
//  - Counter reaching TIMEOUT_CYCLES-1 -> timeout_err pulse, then COMMIT (the move is still committed).
//  COMMIT (1 cycle)
//  - tile[active] <= pend_tile.
//  - If pend_tile == FLAG_TILE: game_over <= 1, winner <= active -> GAME_OVER.
//  - Otherwise active_player toggles -> WAIT_ROLL.
//  GAME_OVER
//  - roll_ready = 0; rolls are ignored with no bad_roll pulse.
//  - new_game pulse: tiles = 0, both target_x = START_X, active = 0, game_over = 0 -> WAIT_ROLL.
//  - No move_start is issued. The downstream movement controller is reset via the shared rst only.
//  Timing
//  - Latency from roll accept to move_start = 2 cycles (accept edge, then ISSUE edge).
//  - rst mid-turn (any state) aborts the turn immediately; there is no pending pulse after reset.
//  - move_start is never asserted on two consecutive cycles.
//  - At most one move is outstanding at a time.
// TESTING
//  1. Reset, then roll 3 -> 2 cycles later player1_move_start pulses, player1_target_x = 200;
//     after player1_turn_done, player1_tile = 3 and active_player = 1.
//  2. P1 at tile 8, roll 6 -> target_x = 620 (clamped); after done, game_over = 1, winner = 0,
//     roll_ready = 0.
//  3. roll_value = 0 and roll_value = 7 in WAIT_ROLL -> one bad_roll pulse each; tiles and
//     state unchanged, no move_start.
//  4. In WAIT_DONE (P1 active), pulse player2_turn_done, then both turn_done together ->
//     the first is ignored; the second commits P1 only.
//  5. TIMEOUT_CYCLES = 16, no turn_done -> timeout_err pulses exactly 16 cycles after WAIT_DONE
//     entry; tile committed; turn passes to P2.
//  6. rst asserted in WAIT_DONE, then new_game after a win -> all outputs return to their reset
//     values; the next roll drives P1.

Source files
------------

// File: rtl/turn_sequencer.sv
// Two-player turn sequencer: accepts die rolls, advances the active player's tile,
// issues a move to the movement controller, and hands over the turn once it completes.
module turn_sequencer #(
  parameter int START_X        = 20,
  parameter int TILE_SPACING   = 60,
  parameter int FLAG_TILE      = 10,
  parameter int TIMEOUT_CYCLES = 2**22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       roll_valid,
  input  logic [2:0] roll_value,
  output logic       roll_ready,
  input  logic       new_game,
  input  logic       player1_turn_done,
  input  logic       player2_turn_done,
  output logic [9:0] player1_target_x,
  output logic       player1_move_start,
  output logic [9:0] player2_target_x,
  output logic       player2_move_start,
  output logic       active_player,
  output logic [3:0] player1_tile,
  output logic [3:0] player2_tile,
  output logic       game_over,
  output logic       winner,
  output logic       bad_roll,
  output logic       timeout_err
);

  localparam int            CW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [3:0]    FLAG    = 4'(FLAG_TILE);
  localparam logic [9:0]    X0      = 10'(START_X);
  localparam logic [9:0]    STEP    = 10'(TILE_SPACING);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_ROLL,
    ISSUE,
    WAIT_DONE,
    COMMIT,
    GAME_OVER
  } state_t;

  state_t        state, state_next;
  logic [3:0]    pend_tile;
  logic [CW-1:0] wd_cnt;

  logic [3:0] tile_act;
  logic [4:0] sum;
  logic [3:0] pend_calc;
  logic [9:0] target_calc;
  logic       accept;
  logic       bad;
  logic       done_act;
  logic       wd_expire;

  assign roll_ready = (state == WAIT_ROLL);

  always_comb begin
    tile_act    = active_player ? player2_tile : player1_tile;
    sum         = {1'b0, tile_act} + {2'b00, roll_value};
    pend_calc   = (sum >= 5'(FLAG_TILE)) ? FLAG : sum[3:0];
    target_calc = X0 + 10'(pend_calc) * STEP;
    done_act    = active_player ? player2_turn_done : player1_turn_done;
    wd_expire   = (wd_cnt == WD_LAST);
    accept      = 1'b0;
    bad         = 1'b0;
    state_next  = state;
    case (state)
      WAIT_ROLL: begin
        if (roll_valid) begin
          if (roll_value != 3'd0 && roll_value != 3'd7) begin
            accept     = 1'b1;
            state_next = ISSUE;
          end else begin
            bad = 1'b1;
          end
        end
      end
      ISSUE:     state_next = WAIT_DONE;
      WAIT_DONE: if (done_act || wd_expire) state_next = COMMIT;
      COMMIT:    state_next = (pend_tile == FLAG) ? GAME_OVER : WAIT_ROLL;
      GAME_OVER: if (new_game) state_next = WAIT_ROLL;
      default:   state_next = WAIT_ROLL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_ROLL;
    else     state <= state_next;
  end

  // Target is loaded on the accept edge so it is already stable when move_start rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_tile          <= '0;
      wd_cnt             <= '0;
      player1_target_x   <= X0;
      player2_target_x   <= X0;
      player1_move_start <= 1'b0;
      player2_move_start <= 1'b0;
      active_player      <= 1'b0;
      player1_tile       <= '0;
      player2_tile       <= '0;
      game_over          <= 1'b0;
      winner             <= 1'b0;
      bad_roll           <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      player1_move_start <= 1'b0;
      player2_move_start <= 1'b0;
      bad_roll           <= bad;
      timeout_err        <= 1'b0;
      case (state)
        WAIT_ROLL: begin
          if (accept) begin
            pend_tile <= pend_calc;
            if (active_player) player2_target_x <= target_calc;
            else               player1_target_x <= target_calc;
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
          if (active_player) player2_move_start <= 1'b1;
          else               player1_move_start <= 1'b1;
        end
        WAIT_DONE: begin
          wd_cnt <= wd_cnt + CW'(1);
          if (!done_act && wd_expire) timeout_err <= 1'b1;
        end
        COMMIT: begin
          if (active_player) player2_tile <= pend_tile;
          else               player1_tile <= pend_tile;
          if (pend_tile == FLAG) begin
            game_over <= 1'b1;
            winner    <= active_player;
          end else begin
            active_player <= ~active_player;
          end
        end
        GAME_OVER: begin
          if (new_game) begin
            player1_tile     <= '0;
            player2_tile     <= '0;
            player1_target_x <= X0;
            player2_target_x <= X0;
            active_player    <= 1'b0;
            game_over        <= 1'b0;
            winner           <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Randomized scoreboard bench for turn_sequencer: a game-level model predicts every
// pulse (move, bad roll, timeout) with its cycle, and a monitor pops and compares them.
module tb_turn_sequencer;

  localparam int TO     = 16;
  localparam int X0     = 20;
  localparam int STEP   = 60;
  localparam int FLAG   = 10;
  localparam int EV_MOVE = 0;
  localparam int EV_BAD  = 1;
  localparam int EV_TO   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       roll_valid;
  logic [2:0] roll_value;
  logic       roll_ready;
  logic       new_game;
  logic       player1_turn_done;
  logic       player2_turn_done;
  logic [9:0] player1_target_x;
  logic       player1_move_start;
  logic [9:0] player2_target_x;
  logic       player2_move_start;
  logic       active_player;
  logic [3:0] player1_tile;
  logic [3:0] player2_tile;
  logic       game_over;
  logic       winner;
  logic       bad_roll;
  logic       timeout_err;

  turn_sequencer #(
    .START_X(X0), .TILE_SPACING(STEP), .FLAG_TILE(FLAG), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .roll_valid(roll_valid), .roll_value(roll_value), .roll_ready(roll_ready),
    .new_game(new_game),
    .player1_turn_done(player1_turn_done), .player2_turn_done(player2_turn_done),
    .player1_target_x(player1_target_x), .player1_move_start(player1_move_start),
    .player2_target_x(player2_target_x), .player2_move_start(player2_move_start),
    .active_player(active_player),
    .player1_tile(player1_tile), .player2_tile(player2_tile),
    .game_over(game_over), .winner(winner),
    .bad_roll(bad_roll), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int kind;
    int player;
    int target;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_compared   = 0;
  int  n_mismatched = 0;

  int m_tile[2];
  int m_target[2];
  int m_active;
  int m_over;
  int m_winner;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int kind, input int player, input int target, input int cyc);
    ev_t e;
    e.kind = kind; e.player = player; e.target = target; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] value);
    roll_valid = valid;
    roll_value = value;
    tick(1);
    roll_valid = 1'b0;
    roll_value = 3'd0;
  endtask

  task automatic model_reset();
    m_tile[0] = 0; m_tile[1] = 0;
    m_target[0] = X0; m_target[1] = X0;
    m_active = 0; m_over = 0; m_winner = 0;
  endtask

  task automatic check_state(input string tag);
    checkOutput({tag, ".p1_tile"}, int'(player1_tile), m_tile[0]);
    checkOutput({tag, ".p2_tile"}, int'(player2_tile), m_tile[1]);
    checkOutput({tag, ".p1_target"}, int'(player1_target_x), m_target[0]);
    checkOutput({tag, ".p2_target"}, int'(player2_target_x), m_target[1]);
    checkOutput({tag, ".active"}, int'(active_player), m_active);
    checkOutput({tag, ".game_over"}, int'(game_over), m_over);
    checkOutput({tag, ".winner"}, int'(winner), m_winner);
    checkOutput({tag, ".roll_ready"}, int'(roll_ready), m_over ? 0 : 1);
  endtask

  task automatic bad_roll_once(input logic [2:0] value);
    push_ev(EV_BAD, 0, 0, cycle + 1);
    applyStimulus(1'b1, value);
  endtask

  // mode: 0 normal done, 1 inactive done first, 2 both dones together, 3 timeout, 4 reset mid-turn
  task automatic do_roll(input int r, input int mode);
    int a, pend, tgt, c, k;
    a    = m_active;
    pend = (m_tile[a] + r > FLAG) ? FLAG : m_tile[a] + r;
    tgt  = X0 + pend * STEP;
    c    = cycle;
    push_ev(EV_MOVE, a, tgt, c + 2);
    applyStimulus(1'b1, 3'(r));
    tick(1);
    m_target[a] = tgt;
    k = $urandom_range(0, 10);
    case (mode)
      3: begin
        push_ev(EV_TO, 0, 0, c + 2 + TO);
        tick(TO + 3);
      end
      4: begin
        tick(k % 6);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        model_reset();
        check_state("mid_turn_reset");
        return;
      end
      default: begin
        tick(k);
        if (mode == 1) begin
          if (a == 0) player2_turn_done = 1'b1; else player1_turn_done = 1'b1;
          tick(1);
          player1_turn_done = 1'b0; player2_turn_done = 1'b0;
        end
        if (mode == 2) begin
          player1_turn_done = 1'b1; player2_turn_done = 1'b1;
        end else if (a == 0) player1_turn_done = 1'b1;
        else                 player2_turn_done = 1'b1;
        tick(1);
        player1_turn_done = 1'b0; player2_turn_done = 1'b0;
        tick(2);
      end
    endcase
    m_tile[a] = pend;
    if (pend == FLAG) begin
      m_over = 1; m_winner = a;
    end else begin
      m_active = 1 - a;
    end
    check_state("after_turn");
  endtask

  task automatic finish_game();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'($urandom_range(0, 7)));
    tick(2);
    check_state("game_over_hold");
    new_game = 1'b1;
    tick(1);
    new_game = 1'b0;
    model_reset();
    check_state("new_game");
  endtask

  task automatic pop_check(input int kind, input int player, input int target);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL unexpected_event: got kind %0d player %0d, expected none (cycle %0d)",
               kind, player, cycle);
    end else begin
      e = exp_q.pop_front();
      checkOutput("ev_kind", kind, e.kind);
      checkOutput("ev_cycle", cycle, e.cyc);
      if (kind == EV_MOVE) begin
        checkOutput("move_player", player, e.player);
        checkOutput("move_target", target, e.target);
      end
    end
  endtask

  logic prev_move = 1'b0;
  always @(negedge clk) begin
    if (player1_move_start || player2_move_start) begin
      checkOutput("move_exclusive", int'(player1_move_start && player2_move_start), 0);
      checkOutput("move_back_to_back", int'(prev_move), 0);
    end
    if (player1_move_start) pop_check(EV_MOVE, 0, int'(player1_target_x));
    if (player2_move_start) pop_check(EV_MOVE, 1, int'(player2_target_x));
    if (bad_roll)           pop_check(EV_BAD, 0, 0);
    if (timeout_err)        pop_check(EV_TO, 0, 0);
    prev_move = player1_move_start || player2_move_start;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] time limit exceeded");
  end

  initial begin
    int r, mode, turns;
    rst = 1'b1;
    roll_valid = 1'b0; roll_value = 3'd0; new_game = 1'b0;
    player1_turn_done = 1'b0; player2_turn_done = 1'b0;
    tick(3);
    rst = 1'b0;
    model_reset();
    check_state("reset");

    bad_roll_once(3'd0);
    tick(1);
    bad_roll_once(3'd7);
    tick(1);
    check_state("bad_rolls");

    do_roll(3, 0);
    do_roll(2, 1);
    do_roll(1, 2);
    do_roll(1, 0);
    do_roll(6, 0);
    finish_game();

    do_roll(4, 0);
    do_roll(5, 3);
    do_roll(2, 4);
    do_roll(4, 0);
    do_roll(1, 0);
    do_roll(4, 0);
    do_roll(1, 0);
    do_roll(6, 0);
    finish_game();

    for (int g = 0; g < 5; g++) begin
      turns = 0;
      while (!m_over && turns < 60) begin
        if ($urandom_range(0, 3) == 0) begin
          bad_roll_once($urandom_range(0, 1) ? 3'd7 : 3'd0);
        end
        r    = $urandom_range(1, 6);
        mode = $urandom_range(0, 9);
        if (mode > 4) mode = 0;
        if (mode == 4 && g != 2) mode = 3;
        do_roll(r, mode);
        turns++;
      end
      if (m_over) finish_game();
    end

    tick(5);
    checkOutput("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
